// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status bit positions and FSM states for the SPI flash target.
// No ports; imported by spi_target_sync and spi_flash_target.
package spi_flash_pkg;

   localparam logic [7:0] CMD_RDSR = 8'h05;
   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_RDID = 8'h9F;
   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_WRDI = 8'h04;
   localparam logic [7:0] CMD_PP   = 8'h02;

   localparam int STATUS_WIP = 0;
   localparam int STATUS_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_OUT,
      ST_PP_IN,
      ST_IGNORE
   } spi_target_state_t;

endpackage

// File: rtl/spi_target_sync.sv
// 2-flop synchronizers plus edge detect for SCLK, CS and MOSI.
// Ports: clk, rst (async, active-low), raw spi_clk/spi_cs/spi_di in; edge strobes and di_s out.
module spi_target_sync
   import spi_flash_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic spi_clk,
   input  logic spi_cs,
   input  logic spi_di,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic di_s
);

   // [1:0] synchronizer stages, [2] previous synchronized value
   logic [2:0] sclk_q, sclk_d;
   logic [2:0] cs_q, cs_d;
   logic [1:0] di_q, di_d;

   always_comb begin
      sclk_d = {sclk_q[1:0], spi_clk};
      cs_d   = {cs_q[1:0], spi_cs};
      di_d   = {di_q[0], spi_di};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_q <= 3'b000;
         cs_q   <= 3'b111;
         di_q   <= 2'b00;
      end else begin
         sclk_q <= sclk_d;
         cs_q   <= cs_d;
         di_q   <= di_d;
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign di_s      = di_q[1];

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash responder: RDSR, RDID, READ served from a byte-wide memory port.
// Ports: clk, rst (async, active-low), SPI pins (spi_clk/cs/di in, spi_do/spi_do_oe out),
// memory port (mem_adr_o, mem_dat_o, mem_we_o, mem_stb_o out; mem_dat_i, mem_ack_i in).
// Define SPI_FLASH_TARGET_PROGRAM_EN to add WREN, WRDI and PP (page program).
module spi_flash_target
   import spi_flash_pkg::*;
#(
   parameter logic [23:0] JEDEC_ID = 24'hEF4016,
   parameter int          MEM_AW   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_di,
   output logic              spi_do,
   output logic              spi_do_oe,
   output logic [MEM_AW-1:0] mem_adr_o,
   output logic [7:0]        mem_dat_o,
   input  logic [7:0]        mem_dat_i,
   output logic              mem_we_o,
   output logic              mem_stb_o,
   input  logic              mem_ack_i
);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, di_s;

   spi_target_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .spi_clk   (spi_clk),
      .spi_cs    (spi_cs),
      .spi_di    (spi_di),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .di_s      (di_s)
   );

   spi_target_state_t state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        sh_in_q, sh_in_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [23:0]       addr_q, addr_d;
   logic [7:0]        out_q, out_d;
   logic              do_q, do_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        rbuf_q, rbuf_d;
   logic              stb_q, stb_d;
   logic [MEM_AW-1:0] adr_q, adr_d;

   logic        wel, wip;
   logic [7:0]  status;
   logic [7:0]  ld_byte;
   logic [7:0]  sh_nxt;
   logic [23:0] addr_nxt;

`ifdef SPI_FLASH_TARGET_PROGRAM_EN
   logic       wel_q, wel_d;
   logic       we_q, we_d;
   logic [7:0] dat_q, dat_d;

   assign wel       = wel_q;
   assign wip       = stb_q & we_q;
   assign mem_we_o  = we_q;
   assign mem_dat_o = dat_q;
`else
   assign wel       = 1'b0;
   assign wip       = 1'b0;
   assign mem_we_o  = 1'b0;
   assign mem_dat_o = 8'h00;
`endif

   always_comb begin
      status             = 8'h00;
      status[STATUS_WIP] = wip;
      status[STATUS_WEL] = wel;
   end

   // Byte loaded into the output shifter at each byte boundary
   always_comb begin
      ld_byte = rbuf_q;
      case (cmd_q)
         CMD_RDSR: ld_byte = status;
         CMD_RDID: begin
            case (byte_idx_q)
               2'd0:    ld_byte = JEDEC_ID[23:16];
               2'd1:    ld_byte = JEDEC_ID[15:8];
               2'd2:    ld_byte = JEDEC_ID[7:0];
               default: ld_byte = 8'h00;
            endcase
         end
         default: ld_byte = rbuf_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_in_d    = sh_in_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      out_d      = out_q;
      do_d       = do_q;
      byte_idx_d = byte_idx_q;
      rbuf_d     = rbuf_q;
      stb_d      = stb_q;
      adr_d      = adr_q;
      sh_nxt     = {sh_in_q[6:0], di_s};
      addr_nxt   = {addr_q[22:0], di_s};
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
      wel_d      = wel_q;
      we_d       = we_q;
      dat_d      = dat_q;
`endif

      // A late ack (even after CS rise) still retires the request
      if (mem_ack_i && stb_q) begin
         stb_d  = 1'b0;
         rbuf_d = mem_dat_i;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 5'd0;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               sh_in_d   = sh_nxt;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd7) begin
                  cmd_d      = sh_nxt;
                  bit_cnt_d  = 5'd0;
                  byte_idx_d = 2'd0;
                  case (sh_nxt)
                     CMD_RDSR: state_d = ST_RD_OUT;
                     CMD_RDID: state_d = ST_RD_OUT;
                     CMD_READ: state_d = ST_ADDR;
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
                     CMD_PP:   state_d = wel_q ? ST_ADDR : ST_IGNORE;
                     CMD_WRDI: begin
                        state_d = ST_IGNORE;
                        wel_d   = 1'b0;
                     end
`endif
                     default:  state_d = ST_IGNORE;
                  endcase
               end
            end
         end
         ST_ADDR: begin
            if (sclk_rise) begin
               addr_d    = addr_nxt;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_d = 5'd0;
                  state_d   = ST_RD_OUT;
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
                  if (cmd_q == CMD_PP) begin
                     state_d = ST_PP_IN;
                  end else begin
                     stb_d = 1'b1;
                     we_d  = 1'b0;
                     adr_d = addr_nxt[MEM_AW-1:0];
                  end
`else
                  stb_d = 1'b1;
                  adr_d = addr_nxt[MEM_AW-1:0];
`endif
               end
            end
         end
         ST_RD_OUT: begin
            if (sclk_fall) begin
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q[2:0] == 3'd0) begin
                  do_d  = ld_byte[7];
                  out_d = {ld_byte[6:0], 1'b0};
                  if (byte_idx_q != 2'd3) begin
                     byte_idx_d = byte_idx_q + 2'd1;
                  end
                  // Prefetch the byte after the one just loaded
                  if (cmd_q == CMD_READ) begin
                     addr_d = addr_q + 24'd1;
                     adr_d  = addr_d[MEM_AW-1:0];
                     stb_d  = 1'b1;
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
                     we_d   = 1'b0;
`endif
                  end
               end else begin
                  do_d  = out_q[7];
                  out_d = {out_q[6:0], 1'b0};
               end
            end
         end
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
         ST_PP_IN: begin
            if (sclk_rise) begin
               sh_in_d   = sh_nxt;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q[2:0] == 3'd7) begin
                  stb_d  = 1'b1;
                  we_d   = 1'b1;
                  dat_d  = sh_nxt;
                  adr_d  = addr_q[MEM_AW-1:0];
                  // Stay within the 256-byte page
                  addr_d = {addr_q[23:8], addr_q[7:0] + 8'd1};
               end
            end
         end
`endif
         default: ;
      endcase

      if (cs_rise) begin
         state_d = ST_IDLE;
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
         if (state_q == ST_IGNORE && cmd_q == CMD_WREN) begin
            wel_d = 1'b1;
         end
         if (cmd_q == CMD_PP && (state_q == ST_ADDR || state_q == ST_PP_IN)) begin
            wel_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 5'd0;
         sh_in_q    <= 8'h00;
         cmd_q      <= 8'h00;
         addr_q     <= 24'h0;
         out_q      <= 8'h00;
         do_q       <= 1'b0;
         byte_idx_q <= 2'd0;
         rbuf_q     <= 8'h00;
         stb_q      <= 1'b0;
         adr_q      <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_in_q    <= sh_in_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         out_q      <= out_d;
         do_q       <= do_d;
         byte_idx_q <= byte_idx_d;
         rbuf_q     <= rbuf_d;
         stb_q      <= stb_d;
         adr_q      <= adr_d;
      end
   end

`ifdef SPI_FLASH_TARGET_PROGRAM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wel_q <= 1'b0;
         we_q  <= 1'b0;
         dat_q <= 8'h00;
      end else begin
         wel_q <= wel_d;
         we_q  <= we_d;
         dat_q <= dat_d;
      end
   end
`endif

   assign spi_do    = do_q;
   assign spi_do_oe = (state_q == ST_RD_OUT);
   assign mem_stb_o = stb_q;
   assign mem_adr_o = adr_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// Randomized bench for spi_flash_target: SPI initiator, memory responder and flash model.
// Set SPI_FLASH_TARGET_PROGRAM_EN to also exercise WREN/WRDI/PP.
module tb_spi_flash_target;

   logic        clk;
   logic        rst;
   logic        spi_clk;
   logic        spi_cs;
   logic        spi_di;
   logic        spi_do;
   logic        spi_do_oe;
   logic [23:0] mem_adr_o;
   logic [7:0]  mem_dat_o;
   logic [7:0]  mem_dat_i;
   logic        mem_we_o;
   logic        mem_stb_o;
   logic        mem_ack_i;

   spi_flash_target dut (
      .clk       (clk),
      .rst       (rst),
      .spi_clk   (spi_clk),
      .spi_cs    (spi_cs),
      .spi_di    (spi_di),
      .spi_do    (spi_do),
      .spi_do_oe (spi_do_oe),
      .mem_adr_o (mem_adr_o),
      .mem_dat_o (mem_dat_o),
      .mem_dat_i (mem_dat_i),
      .mem_we_o  (mem_we_o),
      .mem_stb_o (mem_stb_o),
      .mem_ack_i (mem_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  model_mem [logic [23:0]];
   logic [23:0] adr_log[$];
   logic [31:0] wr_log[$];
   int          stb_cnt = 0;
   int          ack_cnt = 0;
   int          oe_cnt  = 0;
   bit          model_wel = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Memory responder: acks each request 1..3 clk after stb rises
   initial begin
      int d;
      mem_ack_i = 1'b0;
      mem_dat_i = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (mem_stb_o) begin
            stb_cnt++;
            adr_log.push_back(mem_adr_o);
            if (mem_we_o) begin
               model_mem[mem_adr_o] = mem_dat_o;
               wr_log.push_back({mem_dat_o, mem_adr_o});
            end else begin
               mem_dat_i = mem_rd(mem_adr_o);
            end
            d = $urandom_range(0, 2);
            repeat (d) @(posedge clk);
            #1;
            mem_ack_i = 1'b1;
            ack_cnt++;
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!spi_cs && spi_do_oe) oe_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // SCLK = clk/16, mode 0; MISO sampled on SCLK rise
   task automatic xfer(input logic [7:0] tx[$], input int nrx_bits, output logic [7:0] rx[$]);
      int         ntx;
      logic [7:0] cur;
      logic [7:0] sh;
      rx = {};
      sh = 8'h00;
      ntx = tx.size() * 8;
      @(negedge clk);
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
      for (int b = 0; b < ntx + nrx_bits; b++) begin
         if (b < ntx) begin
            cur = tx[b / 8];
            spi_di = cur[7 - (b % 8)];
         end else begin
            spi_di = 1'b0;
         end
         repeat (8) @(negedge clk);
         spi_clk = 1'b1;
         if (b >= ntx) begin
            sh = {sh[6:0], spi_do};
            if (((b - ntx) % 8) == 7) rx.push_back(sh);
         end
         repeat (8) @(negedge clk);
         spi_clk = 1'b0;
      end
      repeat (8) @(negedge clk);
      spi_cs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("oe_off", {31'd0, spi_do_oe}, 32'd0);
      repeat (16) @(negedge clk);
   endtask

   initial begin
      logic [7:0]  rx[$];
      logic [7:0]  tx[$];
      logic [23:0] a;
      logic [7:0]  op;
      logic [7:0]  exp_sr;
      int          n, s0, o0;

      rst = 1'b0;
      spi_clk = 1'b0;
      spi_cs = 1'b1;
      spi_di = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_do", {31'd0, spi_do}, 32'd0);
      chk("rst_oe", {31'd0, spi_do_oe}, 32'd0);
      chk("rst_stb", {31'd0, mem_stb_o}, 32'd0);
      chk("rst_we", {31'd0, mem_we_o}, 32'd0);
      chk("rst_adr", {8'd0, mem_adr_o}, 32'd0);
      chk("rst_dat", {24'd0, mem_dat_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // RDSR after reset
      tx = '{8'h05};
      xfer(tx, 16, rx);
      chk("rdsr_n", rx.size(), 2);
      for (int i = 0; i < 2; i++) chk("rdsr0", (i < rx.size()) ? rx[i] : 32'hBAD, 0);

      // RDID
      tx = '{8'h9F};
      xfer(tx, 32, rx);
      chk("rdid_n", rx.size(), 4);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] idw;
         idw = 32'hEF401600;
         chk("rdid", (i < rx.size()) ? rx[i] : 32'hBAD, idw[31 - 8 * i -: 8]);
      end

      // READ across the top of the address space
      model_mem[24'hFFFFFF] = 8'hAA;
      model_mem[24'h000000] = 8'h55;
      adr_log = {};
      tx = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
      xfer(tx, 16, rx);
      chk("wrap_n", rx.size(), 2);
      chk("wrap_b0", (rx.size() > 0) ? rx[0] : 32'hBAD, 32'hAA);
      chk("wrap_b1", (rx.size() > 1) ? rx[1] : 32'hBAD, 32'h55);
      for (int i = 0; i < 3; i++) begin
         a = 24'hFFFFFF + 24'(i);
         chk("wrap_adr", (i < adr_log.size()) ? {8'd0, adr_log[i]} : 32'hDEADBEEF, {8'd0, a});
      end

      // Random READs
      for (int t = 0; t < 4; t++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) model_mem[a + 24'(i)] = 8'($urandom);
         tx = '{8'h03, a[23:16], a[15:8], a[7:0]};
         xfer(tx, 8 * n, rx);
         chk("rd_n", rx.size(), n);
         for (int i = 0; i < n; i++)
            chk("rd_dat", (i < rx.size()) ? rx[i] : 32'hBAD, mem_rd(a + 24'(i)));
      end

      // Abort half way through a READ data byte
      a = 24'($urandom);
      tx = '{8'h03, a[23:16], a[15:8], a[7:0]};
      xfer(tx, 4, rx);
      chk("abort_bal", stb_cnt, ack_cnt);
      tx = '{8'h05};
      xfer(tx, 8, rx);
      chk("abort_sr", (rx.size() > 0) ? rx[0] : 32'hBAD, 0);

      // Unknown opcodes
      for (int t = 0; t < 3; t++) begin
         if (t == 0) op = 8'hAB;
         else begin
            op = 8'($urandom);
            while (op == 8'h05 || op == 8'h9F || op == 8'h03 ||
                   op == 8'h06 || op == 8'h04 || op == 8'h02) op = 8'($urandom);
         end
         s0 = stb_cnt;
         o0 = oe_cnt;
         tx = '{op, 8'h12, 8'h34, 8'h56};
         xfer(tx, 16, rx);
         chk("unk_oe", oe_cnt - o0, 0);
         chk("unk_stb", stb_cnt - s0, 0);
      end

      // Write enable / page program
      tx = '{8'h06};
      xfer(tx, 0, rx);
`ifdef SPI_FLASH_TARGET_PROGRAM_EN
      model_wel = 1'b1;
`endif
      exp_sr = {6'd0, model_wel, 1'b0};
      tx = '{8'h05};
      xfer(tx, 16, rx);
      for (int i = 0; i < 2; i++) chk("wren_sr", (i < rx.size()) ? rx[i] : 32'hBAD, exp_sr);

      wr_log = {};
      a = 24'h0000FE;
      tx = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h33};
      xfer(tx, 0, rx);
      if (model_wel) begin
         chk("pp_n", wr_log.size(), 3);
         for (int i = 0; i < 3; i++) begin
            logic [7:0]  pd;
            logic [23:0] pa;
            pd = 8'h11 * 8'(i + 1);
            pa = {a[23:8], a[7:0] + 8'(i)};
            chk("pp_wr", (i < wr_log.size()) ? wr_log[i] : 32'hBAD, {pd, pa});
         end
      end else begin
         chk("pp_none", wr_log.size(), 0);
      end
      model_wel = 1'b0;
      tx = '{8'h05};
      xfer(tx, 8, rx);
      chk("pp_sr", (rx.size() > 0) ? rx[0] : 32'hBAD, 0);

      tx = '{8'h03, 8'h00, 8'h00, 8'h00};
      xfer(tx, 8, rx);
      chk("pp_rdbk", (rx.size() > 0) ? rx[0] : 32'hBAD, mem_rd(24'h000000));

      // PP without WEL must not write
      wr_log = {};
      tx = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hAB};
      xfer(tx, 0, rx);
      chk("pp_nowel", wr_log.size(), 0);

      // Asynchronous reset in the middle of a READ
      fork
         begin
            tx = '{8'h03, 8'h00, 8'h10, 8'h00};
            xfer(tx, 16, rx);
         end
         begin
            repeat (600) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("arst_oe", {31'd0, spi_do_oe}, 0);
            chk("arst_stb", {31'd0, mem_stb_o}, 0);
            chk("arst_do", {31'd0, spi_do}, 0);
            @(negedge clk);
            rst = 1'b1;
         end
      join
      repeat (8) @(negedge clk);
      chk("arst_bal", stb_cnt, ack_cnt);
      tx = '{8'h9F};
      xfer(tx, 8, rx);
      chk("arst_rdid", (rx.size() > 0) ? rx[0] : 32'hBAD, 32'hEF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
